// File: rtl/trig_watchdog.sv
// trig_watchdog: watches the fir_trig time-over-threshold bits for a trigger
// that stays asserted too long (baseline run-away) and drives a recovery
// strobe back into fir_trig. Also keeps saturating trigger and stuck-event
// counters for slow-control readout.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for any tot bit while enabled
// S_TRIG    | trigger run in progress, r_len counts consecutive high samples
// S_OVERRIDE| recovery strobe active (pause_override or bsum_reset)
// S_HOLDOFF | post-recovery quiet time, tot ignored
module trig_watchdog #(
    parameter int MAX_TRIG_LEN = 20,
    parameter int OVERRIDE_LEN = 20,
    parameter int MODE         = 0,
    parameter int HOLDOFF      = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       tot,
    input  logic             enable,
    input  logic             clr_counts,
    output logic             pause_override,
    output logic             bsum_reset,
    output logic             stuck,
    output logic [CNT_W-1:0] n_trig,
    output logic [CNT_W-1:0] n_stuck
);

    localparam int LEN_W  = $clog2(MAX_TRIG_LEN);
    localparam int OVR_W  = (OVERRIDE_LEN > 1) ? $clog2(OVERRIDE_LEN) : 1;
    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    localparam logic [LEN_W-1:0]  LEN_LAST  = LEN_W'(MAX_TRIG_LEN - 1);
    localparam logic [OVR_W-1:0]  OVR_LAST  = OVR_W'(OVERRIDE_LEN - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_TRIG     = 2'd1,
        S_OVERRIDE = 2'd2,
        S_HOLDOFF  = 2'd3
    } state_t;

    state_t             r_state, w_state;
    logic [LEN_W-1:0]   r_len, w_len;
    logic [OVR_W-1:0]   r_ovr, w_ovr;
    logic [HOLD_W-1:0]  r_hold, w_hold;
    logic               r_po, w_po;
    logic               r_bsr, w_bsr;
    logic               r_stuck, w_stuck;
    logic [CNT_W-1:0]   r_n_trig, r_n_stuck;
    logic               w_any_trig;
    logic               w_inc_trig, w_inc_stuck;

    assign w_any_trig = enable & (|tot);

    // Next-state, run-length timers and strobe values; disable forces IDLE.
    always_comb begin
        w_state     = r_state;
        w_len       = r_len;
        w_ovr       = r_ovr;
        w_hold      = r_hold;
        w_po        = 1'b0;
        w_bsr       = 1'b0;
        w_inc_trig  = 1'b0;
        w_inc_stuck = 1'b0;
        if (!enable) begin
            w_state = S_IDLE;
            w_len   = '0;
            w_ovr   = '0;
            w_hold  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_trig) begin
                        w_state    = S_TRIG;
                        w_len      = LEN_W'(1);
                        w_inc_trig = 1'b1;
                    end
                end
                S_TRIG: begin
                    if (!w_any_trig) begin
                        w_state = S_IDLE;
                        w_len   = '0;
                    end else if (r_len == LEN_LAST) begin
                        w_state     = S_OVERRIDE;
                        w_len       = '0;
                        w_ovr       = '0;
                        w_inc_stuck = 1'b1;
                        w_po        = (MODE == 0);
                        w_bsr       = (MODE == 1);
                    end else begin
                        w_len = r_len + 1'b1;
                    end
                end
                S_OVERRIDE: begin
                    // bsum_reset is a one-cycle strobe; pause_override is held.
                    if ((MODE == 1) || (r_ovr == OVR_LAST)) begin
                        w_ovr  = '0;
                        w_hold = '0;
                        w_state = (HOLDOFF == 0) ? S_IDLE : S_HOLDOFF;
                    end else begin
                        w_ovr = r_ovr + 1'b1;
                        w_po  = (MODE == 0);
                    end
                end
                S_HOLDOFF: begin
                    if (r_hold == HOLD_LAST) begin
                        w_state = S_IDLE;
                        w_hold  = '0;
                    end else begin
                        w_hold = r_hold + 1'b1;
                    end
                end
                default: begin
                    w_state = S_IDLE;
                    w_len   = '0;
                    w_ovr   = '0;
                    w_hold  = '0;
                end
            endcase
        end
        w_stuck = (w_state == S_OVERRIDE) || (w_state == S_HOLDOFF);
    end

    // FSM state, timers and registered strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_ovr   <= '0;
            r_hold  <= '0;
            r_po    <= 1'b0;
            r_bsr   <= 1'b0;
            r_stuck <= 1'b0;
        end else begin
            r_state <= w_state;
            r_len   <= w_len;
            r_ovr   <= w_ovr;
            r_hold  <= w_hold;
            r_po    <= w_po;
            r_bsr   <= w_bsr;
            r_stuck <= w_stuck;
        end
    end

    // Saturating event counters; clear has priority over an increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_n_trig  <= '0;
            r_n_stuck <= '0;
        end else if (clr_counts) begin
            r_n_trig  <= '0;
            r_n_stuck <= '0;
        end else begin
            if (w_inc_trig && (r_n_trig != {CNT_W{1'b1}}))
                r_n_trig <= r_n_trig + 1'b1;
            if (w_inc_stuck && (r_n_stuck != {CNT_W{1'b1}}))
                r_n_stuck <= r_n_stuck + 1'b1;
        end
    end

    assign pause_override = r_po;
    assign bsum_reset     = r_bsr;
    assign stuck          = r_stuck;
    assign n_trig         = r_n_trig;
    assign n_stuck        = r_n_stuck;

endmodule

// File: tb/tb_trig_watchdog.sv
// Directed bench for trig_watchdog: three instances share stimulus
// (defaults, MODE=1, CNT_W=2) and are checked against hand-computed values.
module tb_trig_watchdog;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] tot = 4'b0;
    logic       enable = 1'b1;
    logic       clr_counts = 1'b0;

    logic        po0, bsr0, st0;
    logic [15:0] nt0, ns0;
    logic        po1, bsr1, st1;
    logic [15:0] nt1, ns1;
    logic        po2, bsr2, st2;
    logic [1:0]  nt2, ns2;

    int n_checks = 0;
    int n_fail   = 0;

    int tcount;
    int cnt_po0, cnt_bsr0, cnt_st0, first_po0;
    int cnt_po1, cnt_bsr1, cnt_st1, first_bsr1;

    always #5 clk = ~clk;

    trig_watchdog dut0 (
        .clk(clk), .reset_n(reset_n), .tot(tot), .enable(enable), .clr_counts(clr_counts),
        .pause_override(po0), .bsum_reset(bsr0), .stuck(st0), .n_trig(nt0), .n_stuck(ns0)
    );

    trig_watchdog #(.MODE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .tot(tot), .enable(enable), .clr_counts(clr_counts),
        .pause_override(po1), .bsum_reset(bsr1), .stuck(st1), .n_trig(nt1), .n_stuck(ns1)
    );

    trig_watchdog #(.CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .tot(tot), .enable(enable), .clr_counts(clr_counts),
        .pause_override(po2), .bsum_reset(bsr2), .stuck(st2), .n_trig(nt2), .n_stuck(ns2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_stats();
        tcount = 0;
        cnt_po0 = 0; cnt_bsr0 = 0; cnt_st0 = 0; first_po0 = 0;
        cnt_po1 = 0; cnt_bsr1 = 0; cnt_st1 = 0; first_bsr1 = 0;
    endtask

    // One rising edge, then sample 1 time unit later and accumulate stats.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            tcount++;
            if (po0)  begin cnt_po0++;  if (first_po0 == 0)  first_po0  = tcount; end
            if (bsr1) begin cnt_bsr1++; if (first_bsr1 == 0) first_bsr1 = tcount; end
            if (bsr0) cnt_bsr0++;
            if (po1)  cnt_po1++;
            if (st0)  cnt_st0++;
            if (st1)  cnt_st1++;
        end
    endtask

    task automatic do_reset();
        tot = 4'b0; enable = 1'b1; clr_counts = 1'b0;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        clr_stats();
    endtask

    initial begin
        clr_stats();
        do_reset();
        chk("rst_po",     {31'b0, po0}, 0);
        chk("rst_stuck",  {31'b0, st0}, 0);
        chk("rst_ntrig",  {16'b0, nt0}, 0);
        chk("rst_nstuck", {16'b0, ns0}, 0);

        // 1: short trigger
        tot = 4'b0001; tick(5);
        tot = 4'b0000; tick(3);
        chk("t1_ntrig",  {16'b0, nt0}, 1);
        chk("t1_nstuck", {16'b0, ns0}, 0);
        chk("t1_po_cnt", cnt_po0, 0);
        chk("t1_st_cnt", cnt_st0, 0);

        // 2: MODE 0 run-away, tot held through the holdoff
        do_reset();
        tot = 4'b0100; tick(60);
        chk("t2_po_first", first_po0, 20);
        chk("t2_po_cnt",   cnt_po0, 20);
        chk("t2_st_cnt",   cnt_st0, 36);
        chk("t2_bsr0_cnt", cnt_bsr0, 0);
        tot = 4'b0000; tick(2);
        chk("t2_nstuck", {16'b0, ns0}, 1);
        chk("t2_ntrig",  {16'b0, nt0}, 2);

        // 3: length boundary, 19 then 20 samples
        do_reset();
        tot = 4'b1000; tick(19);
        tot = 4'b0000; tick(3);
        chk("t3_19_nstuck", {16'b0, ns0}, 0);
        chk("t3_19_po_cnt", cnt_po0, 0);
        clr_stats();
        tot = 4'b1000; tick(20);
        tot = 4'b0000; tick(40);
        chk("t3_20_nstuck", {16'b0, ns0}, 1);
        chk("t3_20_ntrig",  {16'b0, nt0}, 2);
        chk("t3_20_po_first", first_po0, 20);
        chk("t3_20_po_cnt", cnt_po0, 20);

        // 4: MODE 1 single-cycle bsum_reset
        do_reset();
        tot = 4'b0010; tick(40);
        chk("t4_bsr_first", first_bsr1, 20);
        chk("t4_bsr_cnt",   cnt_bsr1, 1);
        chk("t4_po1_cnt",   cnt_po1, 0);
        chk("t4_st1_cnt",   cnt_st1, 17);
        tot = 4'b0000; tick(2);
        chk("t4_ntrig",  {16'b0, nt1}, 2);
        chk("t4_nstuck", {16'b0, ns1}, 1);

        // 5a: async reset in the middle of OVERRIDE
        do_reset();
        tot = 4'b0001; tick(26);
        chk("t5a_po_pre", {31'b0, po0}, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5a_po_async",  {31'b0, po0}, 0);
        chk("t5a_st_async",  {31'b0, st0}, 0);
        chk("t5a_ntrig",     {16'b0, nt0}, 0);
        chk("t5a_nstuck",    {16'b0, ns0}, 0);
        tick(2);
        reset_n = 1'b1;
        tot = 4'b0000;
        tick(1);

        // 5b: enable drop in the middle of OVERRIDE
        do_reset();
        tot = 4'b0001; tick(26);
        enable = 1'b0;
        chk("t5b_po_pre", {31'b0, po0}, 1);
        tick(1);
        chk("t5b_po",     {31'b0, po0}, 0);
        chk("t5b_stuck",  {31'b0, st0}, 0);
        chk("t5b_ntrig",  {16'b0, nt0}, 1);
        chk("t5b_nstuck", {16'b0, ns0}, 1);
        tick(2);
        chk("t5b_po_hold", {31'b0, po0}, 0);
        tot = 4'b0000; enable = 1'b1; tick(2);

        // 6: saturation at CNT_W=2 and clear priority
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tot = 4'b0001; tick(3);
            tot = 4'b0000; tick(2);
        end
        chk("t6_sat_ntrig2", {30'b0, nt2}, 3);
        chk("t6_ntrig0",     {16'b0, nt0}, 5);
        tot = 4'b0001; clr_counts = 1'b1; tick(1);
        chk("t6_clr_ntrig0", {16'b0, nt0}, 0);
        chk("t6_clr_ntrig2", {30'b0, nt2}, 0);
        clr_counts = 1'b0; tick(1);
        chk("t6_post_ntrig0", {16'b0, nt0}, 0);
        tot = 4'b0000; tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
